// File: rtl/mem_ctrl.sv
// Core memory controller: decodes accesses onto RAM, ROM and a handshaked IO port.
// Latency: read data registered, valid 2 edges after a stable address; RAM strobe 1 cycle after store start.
// Backpressure: IO waits on io_ready up to IO_TIMEOUT cycles; starts issued while busy raise bus_err.
module mem_ctrl #(
    parameter int RAM_AW     = 13,
    parameter int IO_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       mem_addr,
    inout  wire  [63:0]       mem_data,
    input  logic [7:0]        mem_mask,
    input  logic [3:0]        size,
    input  logic [1:0]        pulse,
    input  logic              rw,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [63:0]       ram_wdata,
    output logic [7:0]        ram_be,
    output logic              ram_we,
    input  logic [63:0]       ram_rdata,
    output logic [12:0]       rom_addr,
    input  logic [63:0]       rom_rdata,
    output logic [15:0]       io_addr,
    output logic [15:0]       io_wdata,
    output logic [3:0]        io_size,
    output logic              io_rd,
    output logic              io_wr,
    input  logic              io_ready,
    input  logic [63:0]       io_rdata,
    output logic              bus_err,
    input  logic              err_clr
);
    typedef enum logic [1:0] {IDLE, RD_IO, WR_IO} state_t;

    localparam int            TW       = $clog2(IO_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(IO_TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [1:0]    pulse_prev_q, pulse_prev_d;
    logic          rw_prev_q, rw_prev_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [63:0]   rd_q, rd_d;
    logic [63:0]   io_hold_q, io_hold_d;
    logic [63:0]   ram_wdata_q, ram_wdata_d;
    logic [7:0]    ram_be_q, ram_be_d;
    logic          ram_we_q, ram_we_d;
    logic          bus_err_q, bus_err_d;
    logic [15:0]   io_wdata_q, io_wdata_d;
    logic [3:0]    io_size_q, io_size_d;

    logic is_rom, is_io, load_start, store_start, busy, io_done, io_tmo;

    assign is_rom      = &mem_addr[63:16];
    assign is_io       = (&mem_addr[63:32]) && !(&mem_addr[31:16]);
    assign load_start  = (pulse == 2'd1) && (pulse_prev_q != 2'd1) && !rw;
    assign store_start = (pulse == 2'd2) && rw && !((pulse_prev_q == 2'd2) && rw_prev_q);
    assign busy        = (state_q != IDLE);
    assign io_done     = busy && io_ready;
    assign io_tmo      = busy && !io_ready && (tmo_q == TMO_LAST);

    // Upper RAM address bits are dropped, so the RAM image aliases across the space.
    assign ram_addr  = mem_addr[RAM_AW+2:3];
    assign rom_addr  = mem_addr[15:3];
    assign io_addr   = mem_addr[15:0];
    assign ram_wdata = ram_wdata_q;
    assign ram_be    = ram_be_q;
    assign ram_we    = ram_we_q;
    assign io_wdata  = io_wdata_q;
    assign io_size   = io_size_q;
    assign bus_err   = bus_err_q;
    assign mem_data  = rw ? {64{1'bz}} : rd_q;

    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (store_start && is_io)     state_d = WR_IO;
                else if (load_start && is_io) state_d = RD_IO;
            end
            RD_IO, WR_IO: if (io_done || io_tmo) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        io_rd = (state_q == RD_IO);
        io_wr = (state_q == WR_IO);
    end

    always_comb begin
        pulse_prev_d = pulse;
        rw_prev_d    = rw;
        tmo_d        = '0;
        ram_we_d     = 1'b0;
        ram_be_d     = ram_be_q;
        ram_wdata_d  = ram_wdata_q;
        io_wdata_d   = io_wdata_q;
        io_size_d    = io_size_q;
        io_hold_d    = io_hold_q;
        bus_err_d    = bus_err_q & ~err_clr;
        if (is_rom)     rd_d = rom_rdata;
        else if (is_io) rd_d = io_hold_q;
        else            rd_d = ram_rdata;
        if (!busy) begin
            if (store_start) begin
                if (is_rom) begin
                    bus_err_d = 1'b1;
                end else if (is_io) begin
                    io_wdata_d = mem_data[15:0];
                    io_size_d  = size;
                end else begin
                    ram_we_d    = 1'b1;
                    ram_be_d    = mem_mask;
                    ram_wdata_d = mem_data;
                end
            end else if (load_start && is_io) begin
                io_size_d = size;
            end
        end else begin
            // Starts arriving mid-transfer are dropped, not queued.
            if (load_start || store_start) bus_err_d = 1'b1;
            if (io_done) begin
                if (state_q == RD_IO) io_hold_d = io_rdata;
            end else if (io_tmo) begin
                bus_err_d = 1'b1;
                if (state_q == RD_IO) io_hold_d = '0;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pulse_prev_q <= '0;
            rw_prev_q    <= 1'b0;
            tmo_q        <= '0;
            rd_q         <= '0;
            io_hold_q    <= '0;
            ram_wdata_q  <= '0;
            ram_be_q     <= '0;
            ram_we_q     <= 1'b0;
            bus_err_q    <= 1'b0;
            io_wdata_q   <= '0;
            io_size_q    <= '0;
        end else begin
            pulse_prev_q <= pulse_prev_d;
            rw_prev_q    <= rw_prev_d;
            tmo_q        <= tmo_d;
            rd_q         <= rd_d;
            io_hold_q    <= io_hold_d;
            ram_wdata_q  <= ram_wdata_d;
            ram_be_q     <= ram_be_d;
            ram_we_q     <= ram_we_d;
            bus_err_q    <= bus_err_d;
            io_wdata_q   <= io_wdata_d;
            io_size_q    <= io_size_d;
        end
    end
endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level model of the controller.
module tb_mem_ctrl;
    localparam int RAM_AW     = 13;
    localparam int IO_TIMEOUT = 15;
    localparam int R_RAM = 0, R_IO = 1, R_ROM = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [63:0]       mem_addr;
    wire  [63:0]       mem_data;
    logic [63:0]       tb_wdat;
    logic [7:0]        mem_mask;
    logic [3:0]        size;
    logic [1:0]        pulse;
    logic              rw;
    logic [RAM_AW-1:0] ram_addr;
    logic [63:0]       ram_wdata, ram_rdata, rom_rdata, io_rdata;
    logic [7:0]        ram_be;
    logic              ram_we;
    logic [12:0]       rom_addr;
    logic [15:0]       io_addr, io_wdata;
    logic [3:0]        io_size;
    logic              io_rd, io_wr, io_ready, bus_err, err_clr;

    assign mem_data = rw ? tb_wdat : {64{1'bz}};

    mem_ctrl #(.RAM_AW(RAM_AW), .IO_TIMEOUT(IO_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_data(mem_data),
        .mem_mask(mem_mask), .size(size), .pulse(pulse), .rw(rw),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_be(ram_be), .ram_we(ram_we),
        .ram_rdata(ram_rdata), .rom_addr(rom_addr), .rom_rdata(rom_rdata),
        .io_addr(io_addr), .io_wdata(io_wdata), .io_size(io_size), .io_rd(io_rd),
        .io_wr(io_wr), .io_ready(io_ready), .io_rdata(io_rdata),
        .bus_err(bus_err), .err_clr(err_clr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Device contents are fixed functions of the word index.
    function automatic logic [63:0] ram_word(input logic [RAM_AW-1:0] i);
        logic [31:0] x;
        x = 32'(i);
        return {32'hC0DE_0000 | x, (x * 32'h9E37_79B1) ^ 32'h5A5A_5A5A};
    endfunction

    function automatic logic [63:0] rom_word(input logic [12:0] i);
        logic [31:0] x;
        x = 32'(i);
        if (i == 13'd1) return 64'hDEAD;
        return {32'hB007_0000 | x, x * 32'h85EB_CA6B};
    endfunction

    always @(posedge clk) begin
        ram_rdata <= ram_word(ram_addr);
        rom_rdata <= rom_word(rom_addr);
    end

    function automatic int region(input logic [63:0] a);
        if (a >= 64'hFFFF_FFFF_FFFF_0000) return R_ROM;
        if (a >= 64'hFFFF_FFFF_0000_0000) return R_IO;
        return R_RAM;
    endfunction

    function automatic logic [RAM_AW-1:0] ram_idx(input logic [63:0] a);
        return RAM_AW'(a >> 3);
    endfunction

    function automatic logic [12:0] rom_idx(input logic [63:0] a);
        return 13'(a >> 3);
    endfunction

    // Reference model: m_io is the outstanding IO transfer (0 none, 1 read, 2 write),
    // m_left the cycles of patience it still has.
    int          m_io = 0;
    int          m_left = 0;
    logic [63:0] m_hold = '0, m_rd = '0, m_wdata = '0, m_prev_addr = '0;
    logic [7:0]  m_be = '0;
    logic        m_we = 1'b0, m_err = 1'b0, m_prev_rw = 1'b0;
    logic [15:0] m_iow = '0;
    logic [3:0]  m_ios = '0;
    logic [1:0]  m_prev_pulse = '0;

    always @(posedge clk) begin : model_p
        int          k;
        logic        ls, ss, err;
        logic [63:0] src;
        k = region(mem_addr);
        if (k == R_ROM)     src = rom_word(rom_idx(m_prev_addr));
        else if (k == R_IO) src = m_hold;
        else                src = ram_word(ram_idx(m_prev_addr));
        if (!reset) begin
            m_io = 0; m_left = 0; m_hold = '0; m_rd = '0; m_we = 1'b0; m_err = 1'b0;
            m_prev_pulse = '0; m_prev_rw = 1'b0;
        end else begin
            m_rd = src;
            ls   = (pulse == 2'd1) && (m_prev_pulse != 2'd1) && !rw;
            ss   = (pulse == 2'd2) && rw && !((m_prev_pulse == 2'd2) && m_prev_rw);
            err  = 1'b0;
            m_we = 1'b0;
            if (m_io == 0) begin
                if (ss && k == R_ROM) err = 1'b1;
                else if (ss && k == R_IO) begin
                    m_io = 2; m_left = IO_TIMEOUT; m_iow = tb_wdat[15:0]; m_ios = size;
                end else if (ss) begin
                    m_we = 1'b1; m_be = mem_mask; m_wdata = tb_wdat;
                end else if (ls && k == R_IO) begin
                    m_io = 1; m_left = IO_TIMEOUT; m_ios = size;
                end
            end else begin
                if (ls || ss) err = 1'b1;
                m_left = m_left - 1;
                if (io_ready) begin
                    if (m_io == 1) m_hold = io_rdata;
                    m_io = 0;
                end else if (m_left == 0) begin
                    err = 1'b1;
                    if (m_io == 1) m_hold = '0;
                    m_io = 0;
                end
            end
            if (err) m_err = 1'b1;
            else if (err_clr) m_err = 1'b0;
            m_prev_pulse = pulse;
            m_prev_rw    = rw;
        end
        m_prev_addr = mem_addr;
    end

    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            chk("ram_we", ram_we, m_we);
            if (m_we) begin
                chk("ram_be", ram_be, m_be);
                chk("ram_wdata", ram_wdata, m_wdata);
            end
            chk("io_rd", io_rd, m_io == 1);
            chk("io_wr", io_wr, m_io == 2);
            if (m_io == 2) chk("io_wdata", io_wdata, m_iow);
            if (m_io != 0) chk("io_size", io_size, m_ios);
            chk("bus_err", bus_err, m_err);
            chk("mem_data", mem_data, rw ? tb_wdat : m_rd);
            chk("ram_addr", ram_addr, ram_idx(mem_addr));
            chk("rom_addr", rom_addr, rom_idx(mem_addr));
            chk("io_addr", io_addr, mem_addr % 65536);
            chk("rd_wr_excl", io_rd & io_wr, 0);
            chk("we_wr_excl", ram_we & io_wr, 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        a = {$urandom, $urandom};
        case ($urandom_range(0, 5))
            0: a[63:32] = 32'h0;
            1: a[63:16] = 48'hFFFF_FFFF_FFFF;
            2: begin
                a[63:32] = 32'hFFFF_FFFF;
                if (a[31:16] == 16'hFFFF) a[31:16] = 16'h0;
            end
            3: a[63:32] = 32'hFFFF_FFFE;
            4: a[63:16] = 48'hFFFF_FFFF_FFFE;
            default: ;
        endcase
        return a;
    endfunction

    initial begin
        int n;
        reset = 1'b0; mem_addr = '0; tb_wdat = '0; mem_mask = '0; size = 4'd8;
        pulse = 2'd0; rw = 1'b0; io_ready = 1'b0; io_rdata = '0; err_clr = 1'b0;
        repeat (3) tick();
        chk("rst_ram_we", ram_we, 0);
        chk("rst_io_rd", io_rd, 0);
        chk("rst_io_wr", io_wr, 0);
        chk("rst_bus_err", bus_err, 0);
        chk("rst_mem_data", mem_data, 0);
        chk_en = 1'b1;
        reset  = 1'b1;
        tick();

        mem_addr = 64'h10; mem_mask = 8'hF0; tb_wdat = 64'h1122_3344_5566_7788; pulse = 2'd2; rw = 1'b1;
        tick();
        chk("ram_st_we", ram_we, 1);
        chk("ram_st_addr", ram_addr, 2);
        chk("ram_st_be", ram_be, 8'hF0);
        chk("ram_st_wdata", ram_wdata, 64'h1122_3344_5566_7788);
        tick();
        chk("ram_st_we_once", ram_we, 0);
        pulse = 2'd0; rw = 1'b0;
        tick();

        mem_addr = 64'hFFFF_FFFF_FFFF_0008;
        tick(); tick();
        chk("rom_rd_data", mem_data, 64'hDEAD);
        rw = 1'b1; tb_wdat = 64'h5555_AAAA_5555_AAAA;
        #1;
        chk("rom_rw1_release", mem_data, 64'h5555_AAAA_5555_AAAA);
        rw = 1'b0;
        tick();

        mem_addr = 64'hFFFF_FFFF_0000_0004; pulse = 2'd1;
        tick(); chk("io_rd_c1", io_rd, 1);
        tick(); chk("io_rd_c2", io_rd, 1);
        tick(); chk("io_rd_c3", io_rd, 1);
        io_ready = 1'b1; io_rdata = 64'h41;
        tick(); chk("io_rd_done", io_rd, 0);
        io_ready = 1'b0; io_rdata = 64'h9999; pulse = 2'd0;
        tick();
        chk("io_rd_data", mem_data, 64'h41);
        chk("io_rd_no_err", bus_err, 0);

        mem_addr = 64'hFFFF_FFFF_0000_0010; rw = 1'b1; tb_wdat = 64'hCAFE_F00D_1234_BEEF;
        size = 4'd2; pulse = 2'd2; n = 0;
        tick();
        chk("io_wr_wdata", io_wdata, 16'hBEEF);
        chk("io_wr_size", io_size, 2);
        while (io_wr && n < 40) begin
            n++;
            tick();
        end
        chk("io_wr_cycles", n, 15);
        chk("io_tmo_err", bus_err, 1);
        pulse = 2'd0; rw = 1'b0; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("err_clr", bus_err, 0);

        mem_addr = 64'hFFFF_FFFF_FFFF_0000; rw = 1'b1; pulse = 2'd2; n = 0;
        repeat (4) begin tick(); if (ram_we) n++; end
        chk("rom_st_no_we", n, 0);
        chk("rom_st_err", bus_err, 1);
        err_clr = 1'b1; pulse = 2'd0;
        tick();
        err_clr = 1'b0;
        mem_addr = 64'h0000_0000_0001_2348; mem_mask = 8'h0F; tb_wdat = 64'h0123_4567_89AB_CDEF;
        pulse = 2'd2; n = 0;
        repeat (4) begin
            tick();
            if (ram_we) begin
                n++;
                chk("ram_alias_addr", ram_addr, 13'h0469);
            end
        end
        chk("ram_held_once", n, 1);
        chk("ram_held_no_err", bus_err, 0);
        pulse = 2'd0; rw = 1'b0;
        tick();

        mem_addr = 64'hFFFF_FFFF_FFFF_0040; rw = 1'b1; pulse = 2'd2;
        tick();
        pulse = 2'd0; rw = 1'b0;
        tick();
        chk("pre_rst_err", bus_err, 1);
        mem_addr = 64'hFFFF_FFFF_0000_0100; pulse = 2'd1;
        tick(); tick();
        chk("pre_rst_io_rd", io_rd, 1);
        reset = 1'b0;
        tick();
        chk("rst_abort_io_rd", io_rd, 0);
        chk("rst_abort_io_wr", io_wr, 0);
        chk("rst_abort_err", bus_err, 0);
        reset = 1'b1; pulse = 2'd0; io_ready = 1'b1; io_rdata = 64'h77;
        tick();
        chk("idle_ready_ignored", io_rd, 0);
        io_ready = 1'b0;
        tick();

        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 99) < 20) mem_addr = rand_addr();
            if ($urandom_range(0, 99) < 30) begin
                case ($urandom_range(0, 3))
                    0: begin pulse = 2'd0; rw = 1'($urandom_range(0, 1)); end
                    1: begin pulse = 2'd1; rw = 1'b0; end
                    2: begin pulse = 2'd2; rw = 1'b1; end
                    default: begin pulse = 2'($urandom_range(0, 2)); rw = 1'($urandom_range(0, 1)); end
                endcase
            end
            tb_wdat  = {$urandom, $urandom};
            mem_mask = 8'($urandom);
            case ($urandom_range(0, 3))
                0: size = 4'd1;
                1: size = 4'd2;
                2: size = 4'd4;
                default: size = 4'd8;
            endcase
            io_ready = ($urandom_range(0, 11) == 0);
            io_rdata = {$urandom, $urandom};
            err_clr  = ($urandom_range(0, 19) == 0);
            reset    = ($urandom_range(0, 399) != 0);
            tick();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have parameter RAM_AW, default 13, RAM doubleword address width (64 KiB).
REQ-002 SHALL have parameter IO_TIMEOUT, default 15, max cycles to wait for io_ready.
REQ-003 SHALL have ports:
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- mem_addr  in  64  byte address from core.
- mem_data  inout  64  read data out when rw=0; write data in when rw=1.
- mem_mask  in  8  byte enables for RAM store.
- size  in  4  access size in bytes (1/2/4/8).
- pulse  in  2  0 idle, 1 load, 2 store.
- rw  in  1  0 read, 1 write.
- ram_addr  out  RAM_AW  doubleword index.
- ram_wdata  out  64  RAM write data.
- ram_be  out  8  RAM byte enables.
- ram_we  out  1  RAM write strobe.
- ram_rdata  in  64  RAM synchronous read data, 1-cycle latency.
- rom_addr  out  13  ROM doubleword index.
- rom_rdata  in  64  ROM synchronous read data, 1-cycle latency.
- io_addr  out  16  IO register address.
- io_wdata  out  16  IO write data.
- io_size  out  4  IO access size.
- io_rd  out  1  IO read request.
- io_wr  out  1  IO write request.
- io_ready  in  1  IO completion.
- io_rdata  in  64  IO read data, valid with io_ready.
- bus_err  out  1  sticky error flag.
- err_clr  in  1  clears bus_err.

Function
REQ-004 SHALL decode: ROM when mem_addr[63:16]=FFFF_FFFF_FFFF; IO when mem_addr[63:32]=FFFF_FFFF and mem_addr[31:16]!=FFFF; RAM otherwise.
REQ-005 SHALL drive ram_addr=mem_addr[RAM_AW+2:3], rom_addr=mem_addr[15:3], io_addr=mem_addr[15:0]; RAM upper bits ignored (aliasing wrap).
REQ-006 SHALL implement FSM states IDLE, RD_IO, WR_IO; reset to IDLE.
REQ-007 SHALL define load_start = pulse==1 and previous-cycle pulse!=1 and rw=0; store_start = pulse==2 and rw=1 and previous-cycle (pulse==2 and rw=1) false.
REQ-008 SHALL, with rw=0, drive mem_data from a register loaded each cycle from rom_rdata (ROM region), ram_rdata (RAM region) or io_hold (IO region); mem_data valid after second rising edge following stable mem_addr.
REQ-009 SHALL tri-state mem_data whenever rw=1.
REQ-010 SHALL, on store_start in IDLE to RAM, assert ram_we for exactly one cycle with ram_be=mem_mask, ram_wdata=mem_data.
REQ-011 SHALL, on store_start in IDLE to ROM, perform no write and set bus_err.
REQ-012 SHALL, on store_start in IDLE to IO, enter WR_IO, hold io_wr=1, io_wdata=mem_data[15:0], io_size=size until io_ready or timeout.
REQ-013 SHALL, on load_start in IDLE to IO, enter RD_IO, hold io_rd=1 until io_ready; latch io_rdata into io_hold on io_ready.
REQ-014 SHALL count cycles in RD_IO/WR_IO; at IO_TIMEOUT without io_ready return to IDLE, deassert request, set bus_err, and in RD_IO load io_hold=0.
REQ-015 SHALL return to IDLE the cycle after io_ready; io_ready in IDLE ignored.
REQ-016 SHALL ignore load_start/store_start outside IDLE and set bus_err.
REQ-017 SHALL clear bus_err on err_clr=1; a simultaneous set wins.
REQ-018 SHALL never assert io_rd and io_wr, or ram_we and io_wr, in the same cycle.

Reset
REQ-019 SHALL, while reset=0 at a rising edge: state IDLE, ram_we=0, io_rd=0, io_wr=0, bus_err=0, io_hold=0, timeout counter 0, read register 0, edge-detect history cleared.
REQ-020 SHALL abort any IO request mid-operation on reset; io_rd/io_wr low the following cycle.

Verification
REQ-021 RAM store: addr 0x10, mask 0xF0, data 0x1122334455667788, pulse 2, rw 1 -> one-cycle ram_we, ram_addr 2, ram_be F0.
REQ-022 ROM read: addr FFFF_FFFF_FFFF_0008, rom_rdata 0xDEAD -> mem_data 0xDEAD after 2 edges; rw=1 -> mem_data Z.
REQ-023 IO read: addr FFFF_FFFF_0000_0004, pulse 1, io_ready on 3rd cycle with 0x41 -> io_rd 3 cycles, mem_data 0x41, bus_err 0.
REQ-024 IO timeout: IO store, io_ready never -> io_wr high 15 cycles, then low, bus_err 1; err_clr -> 0.
REQ-025 ROM store and store held 4 cycles -> no ram_we, bus_err 1; held RAM store gives single ram_we.
REQ-026 Reset low during RD_IO -> io_rd 0 next cycle, state IDLE, bus_err 0.
